evtbld_reset_sequencer: RTL
===========================

Name: evtbld_reset_sequencer

Overview:
Arbitrates event-builder reset requests and runs one timed reset sequence at a time. Requesters are the debounced push-button pulse and the host command decoder. Each sequence halts triggers, drains in-flight events, asserts a synchronous datapath reset, then holds off before returning to idle. It sits between the button debouncer / command decoder and every event-builder block, including the debouncer's own reset input.

Parameters:
RST_CYCLES, 16, cycles rstOut is held high per sequence (>=1)
DRAIN_TIMEOUT, 1024, maximum cycles spent waiting for evtBusy to fall
HOLDOFF, 256, cycles after rstOut release during which new requests are not accepted
TMR_W, 12, timer width; must hold max(RST_CYCLES, DRAIN_TIMEOUT, HOLDOFF)

Ports:
clock  input  1  system clock; all logic on its rising edge
reset  input  1  asynchronous, active-low reset
btnPulse  input  1  single-cycle request from the button debouncer
cmdReq  input  1  host reset request; level, held until cmdAck
cmdAck  output  1  single-cycle acknowledge of cmdReq
evtBusy  input  1  high while the event builder has an event in flight
haltTrig  output  1  high means triggers must be blocked
rstOut  output  1  active-high synchronous reset to the datapath
drainTimeout  output  1  high when the last sequence's drain ended by timeout
lastSrc  output  2  source of the last sequence: 00 power-on, 01 button, 10 command
rstCount  output  8  completed-sequence count; wraps 255->0
idle  output  1  high in IDLE only

Behaviour:
- States: IDLE, DRAIN, ASSERT, HOLD. There is one shared down-timer.
- Reset (reset=0, asynchronous) forces:
  - state=ASSERT, timer=RST_CYCLES-1
  - rstOut=1, haltTrig=1, cmdAck=0, drainTimeout=0, lastSrc=00, rstCount=0, idle=0
  - The power-on sequence therefore begins without DRAIN.
- IDLE:
  - Outputs: rstOut=0, haltTrig=0, idle=1.
  - btnPulse=1 -> DRAIN next cycle; lastSrc=01.
  - Otherwise cmdReq=1 -> DRAIN next cycle; lastSrc=10.
  - Button has priority when both are high in the same cycle.
  - On entering DRAIN: timer=DRAIN_TIMEOUT-1, haltTrig=1 and idle=0 from the next cycle.
- DRAIN:
  - evtBusy=0 -> ASSERT next cycle; drainTimeout<=0.
  - Else timer==0 -> ASSERT next cycle; drainTimeout<=1.
  - Else the timer decrements.
  - If evtBusy is already 0 on the first DRAIN cycle, DRAIN lasts exactly 1 cycle.
- ASSERT:
  - rstOut=1 for exactly RST_CYCLES consecutive cycles, registered (no glitches).
  - On the entry edge, if cmdReq=1, cmdAck pulses for 1 cycle. This merges a pending command into a button-started sequence. No second ack is issued for the same request.
  - When the timer hits 0 -> HOLD; timer=HOLDOFF-1.
- HOLD:
  - rstOut=0, haltTrig=1.
  - btnPulse is ignored (dropped, not queued). cmdReq remains pending because it is level-held.
  - When the timer hits 0 -> IDLE; rstCount increments (wraps at 255).
  - The power-on sequence also increments rstCount.
- Latency:
  - btnPulse in IDLE at edge k gives haltTrig=1 at k+1.
  - With evtBusy=0, rstOut rises at k+2 and falls at k+2+RST_CYCLES.
  - idle returns at k+2+RST_CYCLES+HOLDOFF.
- cmdAck only ever pulses on ASSERT entry, never in other states.
- evtBusy is a registered signal in the same clock domain; no synchroniser is required.
- Reset asserted mid-sequence aborts immediately to the reset state above.
- lastSrc and drainTimeout hold their values until the next sequence updates them.

Decomposition:
- Shared event-builder package holds:
  - state encoding constants (IDLE=0, DRAIN=1, ASSERT=2, HOLD=3)
  - lastSrc codes
- One sub-module: evtbld_seq_timer, a loadable TMR_W-bit down-counter with load, load value, decrement enable and zero flag. The FSM and output registers stay in the top.

Test Plan:
- Power-on: release reset with defaults -> rstOut high for 16 cycles, haltTrig high for 272 cycles, then idle=1, rstCount=1, lastSrc=00.
- Button, idle datapath: btnPulse one cycle with evtBusy=0 -> haltTrig at +1, rstOut high at +2..+17, idle at +274, lastSrc=01, drainTimeout=0, rstCount=2.
- Drain timeout: evtBusy stuck at 1, cmdReq held -> ASSERT after 1024 DRAIN cycles, drainTimeout=1, cmdAck exactly 1 pulse on ASSERT entry, lastSrc=10.
- Simultaneous requests: btnPulse and cmdReq in the same IDLE cycle -> lastSrc=01, one sequence only, cmdAck pulses once at ASSERT entry.
- Ignored requests: btnPulse during HOLD -> no second sequence, idle returns on schedule. cmdReq raised during HOLD -> new sequence starts 1 cycle after IDLE is reached.
- Async abort: reset low during DRAIN mid-cycle -> rstOut=1 and rstCount=0 immediately, without a clock edge. After release, the full power-on sequence runs.

Source files
------------

// File: rtl/evtbld_reset_sequencer_pkg.sv
// Shared event-builder definitions: reset-sequencer state encoding and
// last-source codes reported on lastSrc.
package evtbld_reset_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_ASSERT = 2'd2,
        ST_HOLD   = 2'd3
    } seq_state_e;

    localparam logic [1:0] SRC_POWERON = 2'b00;
    localparam logic [1:0] SRC_BUTTON  = 2'b01;
    localparam logic [1:0] SRC_COMMAND = 2'b10;

endpackage

// File: rtl/evtbld_seq_timer.sv
// Loadable down-counter shared by all reset-sequence phases; load wins over
// decrement, and the zero flag reflects the current count.
module evtbld_seq_timer
    import evtbld_reset_sequencer_pkg::*;
#(
    parameter int unsigned      TMR_W     = 12,
    parameter logic [TMR_W-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= RESET_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - TMR_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/evtbld_reset_sequencer.sv
// Event-builder reset sequencer: arbitrates button/host requests and runs
// one DRAIN -> ASSERT -> HOLD sequence at a time from a shared down-timer.
module evtbld_reset_sequencer
    import evtbld_reset_sequencer_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned DRAIN_TIMEOUT = 1024,
    parameter int unsigned HOLDOFF       = 256,
    parameter int unsigned TMR_W         = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btnPulse,
    input  logic       cmdReq,
    output logic       cmdAck,
    input  logic       evtBusy,
    output logic       haltTrig,
    output logic       rstOut,
    output logic       drainTimeout,
    output logic [1:0] lastSrc,
    output logic [7:0] rstCount,
    output logic       idle
);

    localparam logic [TMR_W-1:0] LD_RST   = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] LD_DRAIN = TMR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LD_HOLD  = TMR_W'(HOLDOFF - 1);

    seq_state_e       r_state;
    seq_state_e       w_next;
    logic             w_load;
    logic [TMR_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_zero;
    logic             w_ack_nxt;
    logic             w_to_nxt;
    logic [1:0]       w_src_nxt;
    logic [7:0]       w_cnt_nxt;

    logic             r_cmdAck;
    logic             r_haltTrig;
    logic             r_rstOut;
    logic             r_drainTimeout;
    logic [1:0]       r_lastSrc;
    logic [7:0]       r_rstCount;
    logic             r_idle;

    evtbld_seq_timer #(
        .TMR_W     (TMR_W),
        .RESET_VAL (LD_RST)
    ) u_timer (
        .i_clk      (clock),
        .i_rst_n    (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ASSERT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        w_ack_nxt  = 1'b0;
        w_to_nxt   = r_drainTimeout;
        w_src_nxt  = r_lastSrc;
        w_cnt_nxt  = r_rstCount;
        case (r_state)
            ST_IDLE: begin
                if (btnPulse || cmdReq) begin
                    w_next     = ST_DRAIN;
                    w_load     = 1'b1;
                    w_load_val = LD_DRAIN;
                    w_src_nxt  = btnPulse ? SRC_BUTTON : SRC_COMMAND;
                end
            end
            ST_DRAIN: begin
                // A pending command is acknowledged on ASSERT entry regardless
                // of which requester started the sequence.
                if (!evtBusy || w_zero) begin
                    w_next     = ST_ASSERT;
                    w_load     = 1'b1;
                    w_load_val = LD_RST;
                    w_to_nxt   = evtBusy;
                    w_ack_nxt  = cmdReq;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (w_zero) begin
                    w_next     = ST_HOLD;
                    w_load     = 1'b1;
                    w_load_val = LD_HOLD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_zero) begin
                    w_next    = ST_IDLE;
                    w_cnt_nxt = r_rstCount + 8'd1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_next = ST_ASSERT;
        endcase
    end

    // Outputs are registered from the next state so they never glitch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cmdAck       <= 1'b0;
            r_haltTrig     <= 1'b1;
            r_rstOut       <= 1'b1;
            r_drainTimeout <= 1'b0;
            r_lastSrc      <= SRC_POWERON;
            r_rstCount     <= '0;
            r_idle         <= 1'b0;
        end else begin
            r_cmdAck       <= w_ack_nxt;
            r_haltTrig     <= (w_next != ST_IDLE);
            r_rstOut       <= (w_next == ST_ASSERT);
            r_drainTimeout <= w_to_nxt;
            r_lastSrc      <= w_src_nxt;
            r_rstCount     <= w_cnt_nxt;
            r_idle         <= (w_next == ST_IDLE);
        end
    end

    assign cmdAck       = r_cmdAck;
    assign haltTrig     = r_haltTrig;
    assign rstOut       = r_rstOut;
    assign drainTimeout = r_drainTimeout;
    assign lastSrc      = r_lastSrc;
    assign rstCount     = r_rstCount;
    assign idle         = r_idle;

endmodule
